// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 2-way set-associative write-back cache controller (optional CACHE_CTRL_FLUSH_EN)
module cache_ctrl #(
    parameter int DATA_W  = 3,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [2:0]        cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_hit,
    output logic              cpu_busy,
    output logic [2:0]        mem_endereco,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_out,
    output logic [2:0]        mem_enderecoWB,
    output logic [DATA_W-1:0] mem_dadoWB,
    output logic              mem_WB
`ifdef CACHE_CTRL_FLUSH_EN
    ,
    input  logic              flush,
    output logic              flush_done
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_FILL   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
`ifdef CACHE_CTRL_FLUSH_EN
    localparam logic [2:0] S_FLUSH  = 3'd7;
`endif

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [2:0]        state;
    logic              req_we;
    logic [2:0]        req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] fill_data;
    logic [CW-1:0]     cnt;
    logic              way;
    logic              hit_q;

    logic [1:0]        valid [2];
    logic [1:0]        dirty [2];
    logic [1:0]        lru;
    logic [1:0]        tags  [2][2];
    logic [DATA_W-1:0] data  [2][2];

    logic              cur_set;
    logic [1:0]        cur_tag;
    logic              hit0;
    logic              hit1;
    logic              hit;
    logic              hit_way;
    logic              victim;

`ifdef CACHE_CTRL_FLUSH_EN
    logic [1:0]        fl_idx;
    logic              fl_set;
    logic              fl_way;
    assign fl_set = fl_idx[1];
    assign fl_way = fl_idx[0];
`endif

    assign cur_set  = req_addr[0];
    assign cur_tag  = req_addr[2:1];
    assign cpu_busy = (state != S_IDLE);

    always_comb begin
        hit0    = valid[cur_set][0] && (tags[cur_set][0] == cur_tag);
        hit1    = valid[cur_set][1] && (tags[cur_set][1] == cur_tag);
        hit     = hit0 || hit1;
        hit_way = !hit0;
        // Fill empty ways first (way 0 before way 1); only then fall back to LRU.
        if (!valid[cur_set][0])
            victim = 1'b0;
        else if (!valid[cur_set][1])
            victim = 1'b1;
        else
            victim = lru[cur_set];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            req_we         <= 1'b0;
            req_addr       <= '0;
            req_wdata      <= '0;
            fill_data      <= '0;
            cnt            <= '0;
            way            <= 1'b0;
            hit_q          <= 1'b0;
            lru            <= '0;
            cpu_rdata      <= '0;
            cpu_ready      <= 1'b0;
            cpu_hit        <= 1'b0;
            mem_endereco   <= '0;
            mem_read       <= 1'b0;
            mem_enderecoWB <= '0;
            mem_dadoWB     <= '0;
            mem_WB         <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                valid[s] <= '0;
                dirty[s] <= '0;
                for (int w = 0; w < 2; w++) begin
                    tags[s][w] <= '0;
                    data[s][w] <= '0;
                end
            end
`ifdef CACHE_CTRL_FLUSH_EN
            fl_idx         <= '0;
            flush_done     <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
            mem_read  <= 1'b0;
            mem_WB    <= 1'b0;
`ifdef CACHE_CTRL_FLUSH_EN
            flush_done <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
`ifdef CACHE_CTRL_FLUSH_EN
                    if (flush) begin
                        fl_idx <= '0;
                        state  <= S_FLUSH;
                    end else
`endif
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr;
                        req_wdata <= cpu_wdata;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q <= hit;
                    if (hit) begin
                        way          <= hit_way;
                        lru[cur_set] <= ~hit_way;
                        if (req_we) begin
                            data[cur_set][hit_way]  <= req_wdata;
                            dirty[cur_set][hit_way] <= 1'b1;
                        end
                        state <= S_DONE;
                    end else begin
                        way <= victim;
                        if (valid[cur_set][victim] && dirty[cur_set][victim])
                            state <= S_WB;
                        else
                            state <= S_FETCH;
                    end
                end
                S_WB: begin
                    mem_WB         <= 1'b1;
                    mem_enderecoWB <= {tags[cur_set][way], cur_set};
                    mem_dadoWB     <= data[cur_set][way];
                    state          <= S_FETCH;
                end
                S_FETCH: begin
                    mem_endereco <= req_addr;
                    mem_read     <= 1'b1;
                    cnt          <= CW'(MEM_LAT - 1);
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        fill_data <= mem_out;
                        state     <= S_FILL;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_FILL: begin
                    valid[cur_set][way] <= 1'b1;
                    tags[cur_set][way]  <= cur_tag;
                    data[cur_set][way]  <= req_we ? req_wdata : fill_data;
                    dirty[cur_set][way] <= req_we;
                    lru[cur_set]        <= ~way;
                    state               <= S_DONE;
                end
                S_DONE: begin
                    cpu_ready <= 1'b1;
                    cpu_hit   <= hit_q;
                    cpu_rdata <= data[cur_set][way];
                    state     <= S_IDLE;
                end
`ifdef CACHE_CTRL_FLUSH_EN
                S_FLUSH: begin
                    // Hold the walk for a cycle after each pulse so mem_WB returns low between pulses.
                    if (!mem_WB) begin
                        if (dirty[fl_set][fl_way]) begin
                            mem_WB                <= 1'b1;
                            mem_enderecoWB        <= {tags[fl_set][fl_way], fl_set};
                            mem_dadoWB            <= data[fl_set][fl_way];
                            dirty[fl_set][fl_way] <= 1'b0;
                        end
                        if (fl_idx == 2'd3) begin
                            flush_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            fl_idx <= fl_idx + 2'd1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed self-checking bench for cache_ctrl (flush tests under CACHE_CTRL_FLUSH_EN)
module tb_cache_ctrl;

    logic       clock;
    logic       reset;
    logic       cpu_req;
    logic       cpu_we;
    logic [2:0] cpu_addr;
    logic [2:0] cpu_wdata;
    logic [2:0] cpu_rdata;
    logic       cpu_ready;
    logic       cpu_hit;
    logic       cpu_busy;
    logic [2:0] mem_endereco;
    logic       mem_read;
    logic [2:0] mem_out;
    logic [2:0] mem_enderecoWB;
    logic [2:0] mem_dadoWB;
    logic       mem_WB;
`ifdef CACHE_CTRL_FLUSH_EN
    logic       flush;
    logic       flush_done;
`endif

    cache_ctrl #(.DATA_W(3), .MEM_LAT(2)) dut (
        .clock(clock),
        .reset(reset),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .cpu_hit(cpu_hit),
        .cpu_busy(cpu_busy),
        .mem_endereco(mem_endereco),
        .mem_read(mem_read),
        .mem_out(mem_out),
        .mem_enderecoWB(mem_enderecoWB),
        .mem_dadoWB(mem_dadoWB),
        .mem_WB(mem_WB)
`ifdef CACHE_CTRL_FLUSH_EN
        ,
        .flush(flush),
        .flush_done(flush_done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Backing memory: read data appears after the mem_read edge, writebacks land on the mem_WB edge.
    logic [2:0] mem [8];
    bit         loaded;
    always @(posedge clock) begin
        if (!loaded) begin
            mem[0] <= 3'd0; mem[1] <= 3'd1; mem[2] <= 3'd1; mem[3] <= 3'd2;
            mem[4] <= 3'd3; mem[5] <= 3'd3; mem[6] <= 3'd4; mem[7] <= 3'd0;
            loaded <= 1'b1;
        end else begin
            if (mem_read) mem_out <= mem[mem_endereco];
            if (mem_WB) mem[mem_enderecoWB] <= mem_dadoWB;
        end
    end

    int         cyc, n_rd, n_wb, n_rdy, n_fd, overlap, rd_cyc, wb_cyc;
    logic [2:0] rd_a;
    logic [2:0] wb_a [64];
    logic [2:0] wb_d [64];
    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (mem_read) begin n_rd = n_rd + 1; rd_a = mem_endereco; rd_cyc = cyc; end
        if (mem_WB) begin
            if (n_wb < 64) begin wb_a[n_wb] = mem_enderecoWB; wb_d[n_wb] = mem_dadoWB; end
            n_wb = n_wb + 1; wb_cyc = cyc;
        end
        if (mem_read && mem_WB) overlap = overlap + 1;
        if (cpu_ready) n_rdy = n_rdy + 1;
`ifdef CACHE_CTRL_FLUSH_EN
        if (flush_done) n_fd = n_fd + 1;
`endif
    end

    int total, bad;
    int rd_base, wb_base, rdy_base;

    task automatic do_req(input logic we, input logic [2:0] addr, input logic [2:0] wd, input bit hold,
                          output int lat, output logic [2:0] rd, output logic hit);
        @(negedge clock);
        rd_base = n_rd; wb_base = n_wb; rdy_base = n_rdy;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (!hold) cpu_req = 1'b0;
            if (cpu_ready) break;
        end
        cpu_req = 1'b0;
        rd = cpu_rdata;
        hit = cpu_hit;
        if (!cpu_ready) begin
            total++; bad++;
            $display("FAIL req_timeout addr=%0d got no cpu_ready within 40 cycles", addr);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({cpu_ready, cpu_hit, cpu_busy, mem_read, mem_WB, cpu_rdata, mem_endereco, mem_enderecoWB, mem_dadoWB} !== 16'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0",
                {cpu_ready, cpu_hit, cpu_busy, mem_read, mem_WB, cpu_rdata, mem_endereco, mem_enderecoWB, mem_dadoWB});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_miss();
        int lat; logic [2:0] rd; logic hit; bit seen;
        @(negedge clock);
        cpu_we = 1'b0; cpu_addr = 3'd3; cpu_req = 1'b1;
        @(negedge clock);
        cpu_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_read) begin seen = 1; break; end
            @(negedge clock);
        end
        total++; if (!seen) begin bad++; $display("FAIL abort_mem_read_seen got=0 exp=1"); end
        reset = 1'b1;
        #1;
        total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL abort_mem_read got=%b exp=0", mem_read); end
        total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", cpu_busy); end
        @(negedge clock);
        reset = 1'b0;
        do_req(1'b0, 3'd3, 3'd0, 1'b0, lat, rd, hit);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL cold3_hit got=%b exp=0", hit); end
        total++; if (rd !== 3'd2) begin bad++; $display("FAIL cold3_rdata got=%0d exp=2", rd); end
        total++; if (lat !== 7) begin bad++; $display("FAIL cold3_latency got=%0d exp=7", lat); end
        total++; if (n_rd - rd_base !== 1) begin bad++; $display("FAIL cold3_reads got=%0d exp=1", n_rd - rd_base); end
        total++; if (rd_a !== 3'd3) begin bad++; $display("FAIL cold3_read_addr got=%0d exp=3", rd_a); end
    endtask

    task automatic test_hit();
        int lat; logic [2:0] rd; logic hit;
        do_req(1'b0, 3'd3, 3'd0, 1'b0, lat, rd, hit);
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL hit3_hit got=%b exp=1", hit); end
        total++; if (rd !== 3'd2) begin bad++; $display("FAIL hit3_rdata got=%0d exp=2", rd); end
        total++; if (lat !== 3) begin bad++; $display("FAIL hit3_latency got=%0d exp=3", lat); end
        total++; if (n_rd - rd_base !== 0) begin bad++; $display("FAIL hit3_reads got=%0d exp=0", n_rd - rd_base); end
    endtask

    task automatic test_write_evict();
        int lat; logic [2:0] rd; logic hit;
        do_req(1'b1, 3'd5, 3'd7, 1'b0, lat, rd, hit);
        total++; if (rd !== 3'd7) begin bad++; $display("FAIL wr5_rdata got=%0d exp=7", rd); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL wr5_hit got=%b exp=0", hit); end
        total++; if (lat !== 7) begin bad++; $display("FAIL wr5_latency got=%0d exp=7", lat); end
        do_req(1'b0, 3'd1, 3'd0, 1'b0, lat, rd, hit);
        total++; if (rd !== 3'd1) begin bad++; $display("FAIL rd1_rdata got=%0d exp=1", rd); end
        total++; if (n_wb - wb_base !== 0) begin bad++; $display("FAIL rd1_wbs got=%0d exp=0", n_wb - wb_base); end
        do_req(1'b0, 3'd3, 3'd0, 1'b0, lat, rd, hit);
        total++; if (n_wb - wb_base !== 1) begin bad++; $display("FAIL rd3_wbs got=%0d exp=1", n_wb - wb_base); end
        total++; if (wb_a[wb_base] !== 3'd5) begin bad++; $display("FAIL rd3_wb_addr got=%0d exp=5", wb_a[wb_base]); end
        total++; if (wb_d[wb_base] !== 3'd7) begin bad++; $display("FAIL rd3_wb_data got=%0d exp=7", wb_d[wb_base]); end
        total++; if (!(wb_cyc < rd_cyc)) begin bad++; $display("FAIL rd3_wb_order wb_cyc=%0d rd_cyc=%0d need wb first", wb_cyc, rd_cyc); end
        total++; if (lat !== 8) begin bad++; $display("FAIL rd3_latency got=%0d exp=8", lat); end
        total++; if (rd !== 3'd2) begin bad++; $display("FAIL rd3_rdata got=%0d exp=2", rd); end
    endtask

    task automatic test_evicted_read();
        int lat; logic [2:0] rd; logic hit;
        do_req(1'b0, 3'd5, 3'd0, 1'b0, lat, rd, hit);
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL rd5_hit got=%b exp=0", hit); end
        total++; if (rd !== 3'd7) begin bad++; $display("FAIL rd5_rdata got=%0d exp=7", rd); end
        total++; if (lat !== 7) begin bad++; $display("FAIL rd5_latency got=%0d exp=7", lat); end
        total++; if (n_rd - rd_base !== 1) begin bad++; $display("FAIL rd5_reads got=%0d exp=1", n_rd - rd_base); end
    endtask

    task automatic test_req_held();
        int lat; logic [2:0] rd; logic hit;
        do_req(1'b0, 3'd4, 3'd0, 1'b1, lat, rd, hit);
        repeat (8) @(negedge clock);
        total++; if (rd !== 3'd3) begin bad++; $display("FAIL held_rdata got=%0d exp=3", rd); end
        total++; if (n_rdy - rdy_base !== 1) begin bad++; $display("FAIL held_ready_pulses got=%0d exp=1", n_rdy - rdy_base); end
        total++; if (n_rd - rd_base !== 1) begin bad++; $display("FAIL held_reads got=%0d exp=1", n_rd - rd_base); end
        total++; if (cpu_busy !== 1'b0) begin bad++; $display("FAIL held_busy got=%b exp=0", cpu_busy); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL read_wb_overlap got=%0d exp=0", overlap); end
    endtask

`ifdef CACHE_CTRL_FLUSH_EN
    task automatic run_flush(output int wbs, output int dones, output int idle_seen);
        int wb0, fd0; bit done;
        @(negedge clock);
        wb0 = n_wb; fd0 = n_fd; idle_seen = 0; done = 0;
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (flush_done) begin done = 1; break; end
            if (!cpu_busy) idle_seen++;
            @(negedge clock);
        end
        total++; if (!done) begin bad++; $display("FAIL flush_timeout got no flush_done"); end
        repeat (3) @(negedge clock);
        wbs = n_wb - wb0;
        dones = n_fd - fd0;
        wb_base = wb0;
    endtask

    task automatic test_flush();
        int lat, wbs, dones, idle_seen; logic [2:0] rd; logic hit;
        do_req(1'b1, 3'd5, 3'd7, 1'b0, lat, rd, hit);
        total++; if (hit !== 1'b1) begin bad++; $display("FAIL fl_wr5_hit got=%b exp=1", hit); end
        do_req(1'b1, 3'd2, 3'd6, 1'b0, lat, rd, hit);
        total++; if (rd !== 3'd6) begin bad++; $display("FAIL fl_wr2_rdata got=%0d exp=6", rd); end
        run_flush(wbs, dones, idle_seen);
        total++; if (wbs !== 2) begin bad++; $display("FAIL flush_wbs got=%0d exp=2", wbs); end
        total++; if ({wb_a[wb_base], wb_d[wb_base]} !== {3'd2, 3'd6}) begin
            bad++; $display("FAIL flush_first got=%0d/%0d exp=2/6", wb_a[wb_base], wb_d[wb_base]); end
        total++; if ({wb_a[wb_base+1], wb_d[wb_base+1]} !== {3'd5, 3'd7}) begin
            bad++; $display("FAIL flush_second got=%0d/%0d exp=5/7", wb_a[wb_base+1], wb_d[wb_base+1]); end
        total++; if (dones !== 1) begin bad++; $display("FAIL flush_done_pulses got=%0d exp=1", dones); end
        total++; if (idle_seen !== 0) begin bad++; $display("FAIL flush_busy idle_cycles=%0d exp=0", idle_seen); end
        total++; if (overlap !== 0) begin bad++; $display("FAIL flush_overlap got=%0d exp=0", overlap); end
        run_flush(wbs, dones, idle_seen);
        total++; if (wbs !== 0) begin bad++; $display("FAIL reflush_wbs got=%0d exp=0", wbs); end
        total++; if (dones !== 1) begin bad++; $display("FAIL reflush_done_pulses got=%0d exp=1", dones); end
        do_req(1'b0, 3'd2, 3'd0, 1'b0, lat, rd, hit);
        total++; if ({hit, rd} !== {1'b1, 3'd6}) begin bad++; $display("FAIL post_flush_rd2 got=%b/%0d exp=1/6", hit, rd); end
    endtask
`endif

    initial begin
        total = 0; bad = 0;
        cyc = 0; n_rd = 0; n_wb = 0; n_rdy = 0; n_fd = 0; overlap = 0; rd_cyc = 0; wb_cyc = 0; rd_a = '0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
`ifdef CACHE_CTRL_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_reset_mid_miss();
        test_hit();
        test_write_evict();
        test_evicted_read();
        test_req_held();
`ifdef CACHE_CTRL_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
